// File: rtl/hv_generator_folded_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : hv_generator_folded_stream_if                                     |
// | Brief  : Frame-in / beat-out handshake bundle of the folded HV generator.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface hv_generator_folded_stream_if #(
    parameter int NUM_CH        = 214,
    parameter int CHANNEL_WIDTH = 2,
    parameter int FOLD_WIDTH    = 500,
    parameter int CH_W          = 8,
    parameter int NF_W          = 2
);
    logic                            fin_valid;
    logic                            fin_ready;
    logic [NUM_CH*CHANNEL_WIDTH-1:0] features;
    logic                            dout_valid;
    logic                            dout_ready;
    logic [FOLD_WIDTH-1:0]           im_out;
    logic [FOLD_WIDTH-1:0]           projm_out;
    logic [1:0]                      dout_modality;
    logic [CH_W-1:0]                 dout_channel;
    logic [NF_W-1:0]                 dout_fold;
    logic                            dout_last_in_mod;
    logic                            dout_last;

    // master: the generator itself; slave: the surrounding pipeline.
    modport master (
        input  fin_valid, features, dout_ready,
        output fin_ready, dout_valid, im_out, projm_out, dout_modality,
               dout_channel, dout_fold, dout_last_in_mod, dout_last
    );

    modport slave (
        output fin_valid, features, dout_ready,
        input  fin_ready, dout_valid, im_out, projm_out, dout_modality,
               dout_channel, dout_fold, dout_last_in_mod, dout_last
    );
endinterface
`default_nettype wire

// File: rtl/hv_generator_folded_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : hv_generator_folded_stream                                        |
// | Brief  : Folded rule-90 item-memory / projection generator, one beat per   |
// |          (fold, channel) of each accepted feature frame.                   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`ifndef SEED_HV
`define SEED_HV {125{16'hA5C3}}
`endif

module hv_generator_folded_stream #(
    parameter int                      HV_DIMENSION  = 2000,
    parameter int                      NUM_FOLDS     = 4,
    parameter int                      FOLD_WIDTH    = 500,
    parameter int                      CHANNEL_WIDTH = 2,
    parameter int                      MOD0_CHANNELS = 32,
    parameter int                      MOD1_CHANNELS = 77,
    parameter int                      MOD2_CHANNELS = 105,
    parameter logic [HV_DIMENSION-1:0] SEED_HV       = `SEED_HV
) (
    input  logic                         clk,
    input  logic                         rst_n,
    hv_generator_folded_stream_if.master bus
);

    localparam int c_num_ch = MOD0_CHANNELS + MOD1_CHANNELS + MOD2_CHANNELS;
    localparam int c_ch_w   = $clog2(c_num_ch);
    localparam int c_nf_w   = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1;

    localparam logic [c_ch_w-1:0] c_mod1_start = c_ch_w'(MOD0_CHANNELS);
    localparam logic [c_ch_w-1:0] c_mod2_start = c_ch_w'(MOD0_CHANNELS + MOD1_CHANNELS);
    localparam logic [c_ch_w-1:0] c_mod0_last  = c_ch_w'(MOD0_CHANNELS - 1);
    localparam logic [c_ch_w-1:0] c_mod1_last  = c_ch_w'(MOD0_CHANNELS + MOD1_CHANNELS - 1);
    localparam logic [c_ch_w-1:0] c_last_ch    = c_ch_w'(c_num_ch - 1);
    localparam logic [c_nf_w-1:0] c_last_fold  = c_nf_w'(NUM_FOLDS - 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    // Circular rule-90: each bit becomes the XOR of its two ring neighbours.
    function automatic logic [HV_DIMENSION-1:0] f_rule90_hv(input logic [HV_DIMENSION-1:0] x);
        return {x[0], x[HV_DIMENSION-1:1]} ^ {x[HV_DIMENSION-2:0], x[HV_DIMENSION-1]};
    endfunction

    function automatic logic [FOLD_WIDTH-1:0] f_rule90_slice(input logic [FOLD_WIDTH-1:0] x);
        return {x[0], x[FOLD_WIDTH-1:1]} ^ {x[FOLD_WIDTH-2:0], x[FOLD_WIDTH-1]};
    endfunction

    localparam logic [HV_DIMENSION-1:0] c_neg_hv = f_rule90_hv(SEED_HV);

    logic [0:0]                        r_state;
    logic [0:0]                        w_state_next;
    logic                              w_fin_ready;
    logic                              w_dout_valid;
    logic                              w_accept;
    logic                              w_fire;
    logic                              w_ch_last;
    logic                              w_fold_last;
    logic [c_num_ch*CHANNEL_WIDTH-1:0] r_features;
    logic [c_ch_w-1:0]                 r_channel;
    logic [c_nf_w-1:0]                 r_fold;
    logic [c_nf_w-1:0]                 w_next_fold;
    logic [FOLD_WIDTH-1:0]             r_im;
    logic [FOLD_WIDTH-1:0]             w_projm;
    logic [1:0]                        w_modality;
    logic [CHANNEL_WIDTH-1:0]          w_cur_feat;

    logic [FOLD_WIDTH-1:0]    w_seed_slice [NUM_FOLDS];
    logic [FOLD_WIDTH-1:0]    w_neg_slice  [NUM_FOLDS];
    logic [FOLD_WIDTH-1:0]    w_im_start   [NUM_FOLDS];
    logic [CHANNEL_WIDTH-1:0] w_feat       [c_num_ch];

    // Per-fold constant slices; the IM for channel 0 of a fold is rule90 of its NEG slice.
    for (genvar g = 0; g < NUM_FOLDS; g++) begin : g_fold_slice
        assign w_seed_slice[g] = SEED_HV[g*FOLD_WIDTH +: FOLD_WIDTH];
        assign w_neg_slice[g]  = c_neg_hv[g*FOLD_WIDTH +: FOLD_WIDTH];
        assign w_im_start[g]   = f_rule90_slice(c_neg_hv[g*FOLD_WIDTH +: FOLD_WIDTH]);
    end

    for (genvar g = 0; g < c_num_ch; g++) begin : g_feat_unpack
        assign w_feat[g] = r_features[g*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    end

    assign w_accept    = bus.fin_valid & w_fin_ready;
    assign w_fire      = w_dout_valid & bus.dout_ready;
    assign w_ch_last   = (r_channel == c_last_ch);
    assign w_fold_last = (r_fold == c_last_fold);
    assign w_next_fold = r_fold + c_nf_w'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_fire && w_ch_last && w_fold_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State outputs
    always_comb begin
        w_fin_ready  = 1'b0;
        w_dout_valid = 1'b0;
        case (r_state)
            S_IDLE:   w_fin_ready  = 1'b1;
            S_STREAM: w_dout_valid = 1'b1;
            default:  w_fin_ready  = 1'b0;
        endcase
    end

    // Frame latch, beat counters and running IM; everything holds while a beat stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_features <= '0;
            r_channel  <= '0;
            r_fold     <= '0;
            r_im       <= '0;
        end else if (w_accept) begin
            r_features <= bus.features;
            r_channel  <= '0;
            r_fold     <= '0;
            r_im       <= w_im_start[0];
        end else if (w_fire) begin
            if (!w_ch_last) begin
                r_channel <= r_channel + c_ch_w'(1);
                r_im      <= f_rule90_slice(r_im);
            end else if (!w_fold_last) begin
                r_channel <= '0;
                r_fold    <= w_next_fold;
                r_im      <= w_im_start[w_next_fold];
            end else begin
                r_channel <= '0;
                r_fold    <= '0;
            end
        end
    end

    assign w_cur_feat = w_feat[r_channel];

    // Feature code 1 selects the positive seed, 2 the negated one, 0 and 3 give no projection.
    always_comb begin
        w_projm = '0;
        if (w_cur_feat == CHANNEL_WIDTH'(1)) begin
            w_projm = w_seed_slice[r_fold];
        end else if (w_cur_feat == CHANNEL_WIDTH'(2)) begin
            w_projm = w_neg_slice[r_fold];
        end
    end

    always_comb begin
        w_modality = 2'd2;
        if (r_channel < c_mod1_start) begin
            w_modality = 2'd0;
        end else if (r_channel < c_mod2_start) begin
            w_modality = 2'd1;
        end
    end

    assign bus.fin_ready        = w_fin_ready;
    assign bus.dout_valid       = w_dout_valid;
    assign bus.im_out           = r_im;
    assign bus.projm_out        = w_projm;
    assign bus.dout_modality    = w_modality;
    assign bus.dout_channel     = r_channel;
    assign bus.dout_fold        = r_fold;
    assign bus.dout_last_in_mod = w_dout_valid &&
                                  ((r_channel == c_mod0_last) || (r_channel == c_mod1_last) || w_ch_last);
    assign bus.dout_last        = w_dout_valid && w_ch_last && w_fold_last;

endmodule
`default_nettype wire

// File: tb/tb_hv_generator_folded_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_hv_generator_folded_stream                                     |
// | Brief  : Scoreboard bench, HV=16 / 2 folds / channels 1+1+2, seed A5C3.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_hv_generator_folded_stream;

    localparam int HV  = 16;
    localparam int NF  = 2;
    localparam int FW  = 8;
    localparam int CW  = 2;
    localparam int NCH = 4;

    typedef struct packed {
        logic [7:0] im;
        logic [7:0] projm;
        logic [1:0] modality;
        logic [1:0] channel;
        logic       fold;
        logic       last_in_mod;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   ready_mode = 1;
    int   pat_idx = 0;
    logic [15:0] ready_pat = 16'b1011_0010_0110_1001;
    beat_t exp_q[$];

    // NEG = rule90(A5C3) = 9966; rule90 of each NEG fold slice is FF, and rule90(FF) is 00.
    logic [7:0] im_tab   [4] = '{8'hFF, 8'h00, 8'h00, 8'h00};
    logic [7:0] seed_sl  [2] = '{8'hC3, 8'hA5};
    logic [7:0] neg_sl   [2] = '{8'h66, 8'h99};
    logic [1:0] mod_tab  [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    logic       lim_tab  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    hv_generator_folded_stream_if #(
        .NUM_CH(NCH), .CHANNEL_WIDTH(CW), .FOLD_WIDTH(FW), .CH_W(2), .NF_W(1)
    ) bus ();

    hv_generator_folded_stream #(
        .HV_DIMENSION(HV), .NUM_FOLDS(NF), .FOLD_WIDTH(FW), .CHANNEL_WIDTH(CW),
        .MOD0_CHANNELS(1), .MOD1_CHANNELS(1), .MOD2_CHANNELS(2), .SEED_HV(16'hA5C3)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic push_frame(input logic [7:0] feat);
        beat_t b;
        logic [1:0] v;
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < 4; c++) begin
                v             = feat[c*2 +: 2];
                b.im          = im_tab[c];
                b.projm       = (v == 2'd1) ? seed_sl[f] : (v == 2'd2) ? neg_sl[f] : 8'h00;
                b.modality    = mod_tab[c];
                b.channel     = 2'(c);
                b.fold        = 1'(f);
                b.last_in_mod = lim_tab[c];
                b.last        = (f == 1) && (c == 3);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] feat);
        int n = 0;
        @(negedge clk);
        while (!bus.fin_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("fin_ready_timeout", 32'(n), 32'd0);
        bus.fin_valid = 1'b1;
        bus.features  = feat;
        @(posedge clk);
        #1;
        bus.fin_valid = 1'b0;
        push_frame(feat);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.dout_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n >= 300), 32'd0);
    endtask

    // Ready driver: 0 = stall, 1 = always ready, otherwise the fixed stall pattern.
    initial begin
        bus.dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.dout_ready = 1'b0;
                1:       bus.dout_ready = 1'b1;
                default: begin
                    bus.dout_ready = ready_pat[pat_idx];
                    pat_idx        = (pat_idx + 1) % 16;
                end
            endcase
        end
    end

    // Monitor: every valid cycle is compared against the head; stalled beats must match it again.
    initial begin
        beat_t got;
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.dout_valid) begin
                got = {bus.im_out, bus.projm_out, bus.dout_modality, bus.dout_channel,
                       bus.dout_fold, bus.dout_last_in_mod, bus.dout_last};
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_beat: got %h expected none", got);
                end else begin
                    e = exp_q[0];
                    if (got === e) pass_cnt++;
                    else $display("FAIL beat f%0d c%0d: got %h expected %h", e.fold, e.channel, got, e);
                    if (bus.dout_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        bus.fin_valid  = 1'b0;
        bus.features   = '0;
        repeat (3) @(negedge clk);
        chk("rst_fin_ready", 32'(bus.fin_ready), 32'd1);
        chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        chk("rst_im_out", 32'(bus.im_out), 32'd0);
        chk("rst_tags", {25'd0, bus.dout_modality, bus.dout_channel, bus.dout_fold,
                         bus.dout_last_in_mod, bus.dout_last}, 32'd0);
        rst_n = 1'b1;

        // T1: ch0=1, ch1=2, ch2=0, ch3=3 with no backpressure -> 8 back-to-back beats
        send_frame(8'hC9);
        @(negedge clk);
        #1;
        chk("t1_latency_valid", 32'(bus.dout_valid), 32'd1);
        chk("t1_fin_ready_busy", 32'(bus.fin_ready), 32'd0);
        repeat (8) @(negedge clk);
        #1;
        chk("t1_drained_in_8", 32'(exp_q.size()), 32'd0);
        chk("t1_valid_low", 32'(bus.dout_valid), 32'd0);
        chk("t1_fin_ready_back", 32'(bus.fin_ready), 32'd1);

        // T2: ch0=2, ch1=3, ch2=1, ch3=2 under a stall pattern
        ready_mode = 2;
        send_frame(8'h9E);
        wait_drain("t2_drain");
        ready_mode = 1;

        // T3: fin_valid held high with changing features; only accept-time features count
        @(negedge clk);
        bus.fin_valid = 1'b1;
        bus.features  = 8'hC9;
        @(posedge clk);
        #1;
        push_frame(8'hC9);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t3_fin_ready_low", 32'(bus.fin_ready), 32'd0);
            bus.features = 8'h3C ^ 8'(i);
        end
        @(negedge clk);
        chk("t3_fin_ready_after_last", 32'(bus.fin_ready), 32'd1);
        bus.features = 8'h9E;
        @(posedge clk);
        #1;
        push_frame(8'h9E);
        bus.fin_valid = 1'b0;
        wait_drain("t3_drain");

        // T5: stall on fold 1 ch 1, reset mid-frame, then a fresh frame
        send_frame(8'hC9);
        repeat (5) @(posedge clk);
        ready_mode = 0;
        repeat (3) @(negedge clk);
        chk("t5_stalled_channel", 32'(bus.dout_channel), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid_low", 32'(bus.dout_valid), 32'd0);
        chk("t5_im_cleared", 32'(bus.im_out), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n      = 1'b1;
        ready_mode = 1;
        #1;
        chk("t5_fin_ready_release", 32'(bus.fin_ready), 32'd1);
        send_frame(8'h9E);
        wait_drain("t5_drain");

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
